// File: rtl/keccak_arbiter_pkg.sv
// keccak_arbiter_pkg
//   Shared constants and types for the keccak core arbiter and its helpers.
//   - Stream / length widths of the keccak core configuration interface.
//   - Keccak mode encodings (passed through unchecked by the arbiter).
//   - Arbiter FSM state encoding.
package keccak_arbiter_pkg;

    localparam int DW           = 64;
    localparam int IBYTES_LEN_W = 11;
    localparam int OBYTES_LEN_W = 10;

    typedef enum logic [1:0] {
        SHA3_256 = 2'd0,
        SHA3_512 = 2'd1,
        SHAKE128 = 2'd2,
        SHAKE256 = 2'd3
    } keccak_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/keccak_arbiter_if.sv
// keccak_arbiter_if
//   Bundles the requester-side and core-side streams of the keccak arbiter.
//   modport slave  : arbiter view (takes requests and core results, drives
//                    grants, core config/input and requester results)
//   modport master : environment view (requesters + keccak core)
//   Per-requester fields are packed, requester k occupying slice k.
interface keccak_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = keccak_arbiter_pkg::DW
);
    import keccak_arbiter_pkg::*;

    logic [NREQ-1:0]              i_req;
    logic [2*NREQ-1:0]            i_req_mode;
    logic [IBYTES_LEN_W*NREQ-1:0] i_req_ibytes_len;
    logic [OBYTES_LEN_W*NREQ-1:0] i_req_obytes_len;
    logic [DW*NREQ-1:0]           i_req_ibytes;
    logic [NREQ-1:0]              i_req_ibytes_valid;
    logic [NREQ-1:0]              o_req_ibytes_ready;
    logic [DW-1:0]                o_req_obytes;
    logic [NREQ-1:0]              o_req_obytes_valid;
    logic [NREQ-1:0]              o_req_done;
    logic [NREQ-1:0]              o_gnt;
    logic                         o_busy;
    logic [1:0]                   o_k_mode;
    logic [IBYTES_LEN_W-1:0]      o_k_ibytes_len;
    logic [OBYTES_LEN_W-1:0]      o_k_obytes_len;
    logic [DW-1:0]                o_k_ibytes;
    logic                         o_k_ibytes_valid;
    logic                         i_k_ibytes_ready;
    logic [DW-1:0]                i_k_obytes;
    logic                         i_k_obytes_valid;
    logic                         i_k_obytes_done;

    modport slave (
        input  i_req, i_req_mode, i_req_ibytes_len, i_req_obytes_len,
               i_req_ibytes, i_req_ibytes_valid,
               i_k_ibytes_ready, i_k_obytes, i_k_obytes_valid, i_k_obytes_done,
        output o_req_ibytes_ready, o_req_obytes, o_req_obytes_valid, o_req_done,
               o_gnt, o_busy, o_k_mode, o_k_ibytes_len, o_k_obytes_len,
               o_k_ibytes, o_k_ibytes_valid
    );

    modport master (
        output i_req, i_req_mode, i_req_ibytes_len, i_req_obytes_len,
               i_req_ibytes, i_req_ibytes_valid,
               i_k_ibytes_ready, i_k_obytes, i_k_obytes_valid, i_k_obytes_done,
        input  o_req_ibytes_ready, o_req_obytes, o_req_obytes_valid, o_req_done,
               o_gnt, o_busy, o_k_mode, o_k_ibytes_len, o_k_obytes_len,
               o_k_ibytes, o_k_ibytes_valid
    );

endinterface

// File: rtl/keccak_arbiter_rr_pick.sv
// keccak_arbiter_rr_pick
//   Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : index of the last served requester; search starts at ptr_i+1
//   gnt_o : one-hot winner (0 when no request)
//   idx_o : binary index of the winner
//   vld_o : at least one request present
module keccak_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);
    import keccak_arbiter_pkg::*;

    int            c;
    logic [IW-1:0] ci;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        ci    = '0;
        // Offset 1..N walks every requester once, ending on ptr itself,
        // so the last-served requester has the lowest priority.
        for (int off = 1; off <= N; off++) begin
            c = int'(ptr_i) + off;
            if (c >= N) begin
                c = c - N;
            end
            ci = IW'(c);
            if (!vld_o && req_i[ci]) begin
                vld_o     = 1'b1;
                gnt_o[ci] = 1'b1;
                idx_o     = ci;
            end
        end
    end

endmodule

// File: rtl/keccak_arbiter.sv
// keccak_arbiter
//   Shares one keccak core among NREQ requesters. Ownership is granted
//   round-robin; the winner's mode and lengths are latched into the core
//   configuration and frozen until the transaction ends. Streams pass
//   through combinationally while RUN.
//   Ports:
//     i_clk  : clock
//     i_rstn : asynchronous active-low reset (must also reset the core)
//     bus    : keccak_arbiter_if.slave - requester and core streams,
//              grant, busy and core configuration
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no owner; pick a requester and latch its config
//   LOAD    | config stable, core input valid held low for one cycle
//   RUN     | streams passed through; core done ends the transaction
//   RELEASE | one idle cycle so the core sees valid low; grant dropped
module keccak_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = keccak_arbiter_pkg::DW
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    keccak_arbiter_if.slave bus
);
    import keccak_arbiter_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e              state_q;
    logic [NREQ-1:0]         gnt_q;
    logic [IW-1:0]           gidx_q;
    logic [IW-1:0]           ptr_q;
    logic [1:0]              mode_q;
    logic [IBYTES_LEN_W-1:0] ilen_q;
    logic [OBYTES_LEN_W-1:0] olen_q;

    logic [NREQ-1:0]         pick_gnt;
    logic [IW-1:0]           pick_idx;
    logic                    pick_vld;
    logic [1:0]              pick_mode;
    logic [IBYTES_LEN_W-1:0] pick_ilen;
    logic [OBYTES_LEN_W-1:0] pick_olen;
    logic [DW-1:0]           own_ibytes;
    logic                    run;

    keccak_arbiter_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req_i (bus.i_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // One-hot muxes: config of the candidate, input word of the owner.
    always_comb begin
        pick_mode  = '0;
        pick_ilen  = '0;
        pick_olen  = '0;
        own_ibytes = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_gnt[k]) begin
                pick_mode = bus.i_req_mode[2*k +: 2];
                pick_ilen = bus.i_req_ibytes_len[IBYTES_LEN_W*k +: IBYTES_LEN_W];
                pick_olen = bus.i_req_obytes_len[OBYTES_LEN_W*k +: OBYTES_LEN_W];
            end
            if (gnt_q[k]) begin
                own_ibytes = bus.i_req_ibytes[DW*k +: DW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(NREQ - 1);
            mode_q  <= '0;
            ilen_q  <= '0;
            olen_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_gnt;
                        gidx_q  <= pick_idx;
                        mode_q  <= pick_mode;
                        ilen_q  <= pick_ilen;
                        olen_q  <= pick_olen;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= RUN;
                end
                RUN: begin
                    // The owner's request is not looked at here: a started
                    // core transaction always runs to its done pulse.
                    if (bus.i_k_obytes_done) begin
                        ptr_q   <= gidx_q;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign run = (state_q == RUN);

    assign bus.o_gnt          = gnt_q;
    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_k_mode       = mode_q;
    assign bus.o_k_ibytes_len = ilen_q;
    assign bus.o_k_obytes_len = olen_q;

    assign bus.o_k_ibytes         = run ? own_ibytes : '0;
    assign bus.o_k_ibytes_valid   = run & (|(gnt_q & bus.i_req_ibytes_valid));
    assign bus.o_req_ibytes_ready = run ? (gnt_q & {NREQ{bus.i_k_ibytes_ready}}) : '0;
    assign bus.o_req_obytes       = run ? bus.i_k_obytes : '0;
    assign bus.o_req_obytes_valid = run ? (gnt_q & {NREQ{bus.i_k_obytes_valid}}) : '0;
    assign bus.o_req_done         = run ? (gnt_q & {NREQ{bus.i_k_obytes_done}}) : '0;

endmodule
